// File: rtl/uart_tx_arbiter_if.sv
// Bundle between uart_tx_arbiter and its environment: the requester byte
// streams, the TX FIFO write port, and arbitration status.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           fifo_wdata;
  logic                 fifo_write;
  logic                 fifo_full;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 abort;
  logic [IDX_W-1:0]     abort_port;

  // Arbiter side.
  modport master (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wdata, fifo_write, grant, busy, abort, abort_port
  );

  // Environment side: requesters plus the FIFO.
  modport slave (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wdata, fifo_write, grant, busy, abort, abort_port
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX FIFO among NUM_REQ
// byte-stream requesters. Each packet is prefixed with a channel tag byte and
// an owner that goes idle too long mid-packet is dropped.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter logic [7:0]  HDR_BASE = 8'hF0,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               reset,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;
  logic [IDX_W-1:0]   abort_port_q, abort_port_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;
  logic [7:0]         fifo_wdata;
  logic               fifo_write;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] grant;

  // Round-robin pick: first valid requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (!pick_found && bus.req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Owner's stream and the pointer value used when its packet ends.
  always_comb begin
    g_valid  = bus.req_valid[gidx_q];
    g_last   = bus.req_last[gidx_q];
    g_data   = bus.req_data[{gidx_q, 3'b000} +: 8];
    ptr_next = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
  end

  // Next-state, handshake and FIFO write decode.
  always_comb begin
    state_d      = state_q;
    gidx_d       = gidx_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    abort_d      = 1'b0;
    abort_port_d = abort_port_q;
    fifo_wdata   = '0;
    fifo_write   = 1'b0;
    req_ready    = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          state_d = StHdr;
        end
      end
      StHdr: begin
        fifo_wdata = HDR_BASE + 8'(gidx_q);
        fifo_write = !bus.fifo_full;
        if (!bus.fifo_full) begin
          cnt_d   = '0;
          state_d = StPayload;
        end
      end
      StPayload: begin
        req_ready[gidx_q] = !bus.fifo_full;
        fifo_wdata        = g_data;
        fifo_write        = g_valid && !bus.fifo_full;
        if (g_valid) begin
          // A valid byte, even one stalled by a full FIFO, is not idleness.
          cnt_d = '0;
          if (!bus.fifo_full && g_last) begin
            ptr_d   = ptr_next;
            state_d = StIdle;
          end
        end else if (TIMEOUT != 0) begin
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            cnt_d        = '0;
            abort_d      = 1'b1;
            abort_port_d = gidx_q;
            ptr_d        = ptr_next;
            state_d      = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // One-hot owner decode; empty while idle.
  always_comb begin
    grant = '0;
    if (state_q != StIdle) begin
      grant[gidx_q] = 1'b1;
    end
  end

  // State registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      gidx_q       <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      abort_port_q <= '0;
    end else begin
      state_q      <= state_d;
      gidx_q       <= gidx_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      abort_port_q <= abort_port_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.fifo_wdata = fifo_wdata;
  assign bus.fifo_write = fifo_write;
  assign bus.grant      = grant;
  assign bus.busy       = (state_q != StIdle);
  assign bus.abort      = abort_q;
  assign bus.abort_port = abort_port_q;

endmodule
